// File: rtl/out_capture_pkg.sv
//------------------------------------------------------------------------------
// Module : out_capture_pkg
// Brief  : Register map, entry width and read-FSM states for out_capture.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package out_capture_pkg;

    localparam int ENTRY_W = 13;

    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_LEVEL_LO = 3'd1;
    localparam logic [2:0] REG_LEVEL_HI = 3'd2;
    localparam logic [2:0] REG_DATA_LO  = 3'd3;
    localparam logic [2:0] REG_DATA_HI  = 3'd4;
    localparam logic [2:0] REG_DROPPED  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_ACK      = 2'd2,
        ST_WAIT_REL = 2'd3
    } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/out_capture_fifo.sv
//------------------------------------------------------------------------------
// Module : out_capture_fifo
// Brief  : Synchronous FIFO, block-RAM storage, registered head read.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module out_capture_fifo
    import out_capture_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    output logic [ENTRY_W-1:0] rd_data,
    output logic [ADDR_W:0]    level,
    output logic               full,
    output logic               empty
);

    localparam int              DEPTH    = 2**ADDR_W;
    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic               do_push;
    logic               do_pop;

    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
    assign do_push = push && (!full || pop) && !clr;
    assign do_pop  = pop && !empty && !clr;
    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
        rd_data <= mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/out_capture.sv
//------------------------------------------------------------------------------
// Module : out_capture
// Brief  : Captures CPU OUT1/OUT2 words into a FIFO, serves them as host byte regs.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module out_capture
    import out_capture_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        out_strobe,
    input  logic        out_select,
    input  logic [11:0] out_data,
    input  logic        host_clr,
    input  logic        host_rd_req,
    input  logic [2:0]  host_rd_addr,
    output logic [7:0]  host_rd_data,
    output logic        host_rd_ack,
    output logic        out_pending
);

    rd_state_t          state;
    rd_state_t          state_nxt;
    logic               pop;
    logic               drop;
    logic               overflow;
    logic [7:0]         dropped;
    logic [ENTRY_W-1:0] head;
    logic [ADDR_W:0]    level;
    logic               full;
    logic               empty;

    logic [ADDR_W:0]    snap_level;
    logic               snap_full;
    logic               snap_empty;
    logic               snap_overflow;
    logic [7:0]         snap_dropped;
    logic [15:0]        level16;
    logic [7:0]         reg_mux;

    out_capture_fifo #(.ADDR_W(ADDR_W)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clr       (host_clr),
        .push      (out_strobe),
        .push_data ({out_select, out_data}),
        .pop       (pop),
        .rd_data   (head),
        .level     (level),
        .full      (full),
        .empty     (empty)
    );

    assign drop        = out_strobe && !host_clr && full && !pop;
    assign out_pending = !empty;

    always_ff @(posedge clk) begin
        if (reset || host_clr) begin
            overflow <= 1'b0;
            dropped  <= 8'h00;
        end else if (drop) begin
            overflow <= 1'b1;
            if (dropped != 8'hFF) begin
                dropped <= dropped + 8'h01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        host_rd_ack = 1'b0;
        case (state)
            ST_IDLE:     if (host_rd_req) state_nxt = ST_FETCH;
            ST_FETCH:    state_nxt = ST_ACK;
            ST_ACK: begin
                host_rd_ack = 1'b1;
                pop         = (host_rd_addr == REG_DATA_HI) && !snap_empty;
                state_nxt   = ST_WAIT_REL;
            end
            ST_WAIT_REL: if (!host_rd_req) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Status is frozen in FETCH; a clear in that cycle is reported as the post-clear view.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_level    <= '0;
            snap_full     <= 1'b0;
            snap_empty    <= 1'b1;
            snap_overflow <= 1'b0;
            snap_dropped  <= 8'h00;
        end else if (state == ST_FETCH) begin
            snap_level    <= host_clr ? '0    : level;
            snap_full     <= host_clr ? 1'b0  : full;
            snap_empty    <= host_clr ? 1'b1  : empty;
            snap_overflow <= host_clr ? 1'b0  : overflow;
            snap_dropped  <= host_clr ? 8'h00 : dropped;
        end
    end

    assign level16 = 16'(snap_level);

    always_comb begin
        reg_mux = 8'h00;
        case (host_rd_addr)
            REG_STATUS:   reg_mux = {snap_overflow, snap_full, snap_empty, 5'b0};
            REG_LEVEL_LO: reg_mux = level16[7:0];
            REG_LEVEL_HI: reg_mux = level16[15:8];
            REG_DATA_LO:  reg_mux = snap_empty ? 8'h00 : head[7:0];
            REG_DATA_HI:  reg_mux = snap_empty ? 8'h00 : {3'b0, head[12:8]};
            REG_DROPPED:  reg_mux = snap_dropped;
            default:      reg_mux = 8'h00;
        endcase
    end

    assign host_rd_data = (state == ST_ACK) ? reg_mux : 8'h00;

endmodule

`default_nettype wire

// File: tb/tb_out_capture.sv
//------------------------------------------------------------------------------
// Module : tb_out_capture
// Brief  : Scoreboard bench for out_capture: directed host reads and CPU strobes.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_out_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        out_strobe = 1'b0;
    logic        out_select = 1'b0;
    logic [11:0] out_data = 12'h000;
    logic        host_clr = 1'b0;
    logic        host_rd_req = 1'b0;
    logic [2:0]  host_rd_addr = 3'd0;
    logic [7:0]  host_rd_data;
    logic        host_rd_ack;
    logic        out_pending;

    typedef struct {
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    out_capture #(.ADDR_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .out_strobe   (out_strobe),
        .out_select   (out_select),
        .out_data     (out_data),
        .host_clr     (host_clr),
        .host_rd_req  (host_rd_req),
        .host_rd_addr (host_rd_addr),
        .host_rd_data (host_rd_data),
        .host_rd_ack  (host_rd_ack),
        .out_pending  (out_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every ack pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (host_rd_ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got data %0h expected no ack", host_rd_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.name, {24'h0, host_rd_data}, {24'h0, e.val});
            end
        end
    end

    // hold: extra cycles req stays high after ack; strobe_ack: push a word during the ACK cycle.
    task automatic do_read(input logic [2:0] addr, input logic [7:0] val, input string name,
                           input int hold, input logic strobe_ack,
                           input logic sel, input logic [11:0] dat);
        int   cyc;
        int   acks;
        exp_t e;
        e.val = val;
        e.name = name;
        exp_q.push_back(e);
        @(posedge clk); #1;
        host_rd_addr = addr;
        host_rd_req  = 1'b1;
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (host_rd_ack) begin
                cyc = i;
                break;
            end
        end
        check({name, "_latency"}, cyc, 2);
        if (strobe_ack) begin
            out_strobe = 1'b1;
            out_select = sel;
            out_data   = dat;
        end
        acks = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            out_strobe = 1'b0;
            if (host_rd_ack) acks++;
        end
        if (hold > 0) check({name, "_single_ack"}, acks, 0);
        host_rd_req = 1'b0;
        @(posedge clk); #1;
        out_strobe = 1'b0;
    endtask

    task automatic rd(input logic [2:0] addr, input logic [7:0] val, input string name);
        do_read(addr, val, name, 0, 1'b0, 1'b0, 12'h000);
    endtask

    task automatic strobe_n(input int n, input logic sel, input logic [11:0] base);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            out_strobe = 1'b1;
            out_select = sel;
            out_data   = base + 12'(i);
        end
        @(posedge clk); #1;
        out_strobe = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_pending", {31'h0, out_pending}, 0);
        check("reset_ack", {31'h0, host_rd_ack}, 0);
        check("reset_data", {24'h0, host_rd_data}, 0);

        rd(3'd0, 8'h20, "status_empty");
        rd(3'd1, 8'h00, "level_lo_empty");
        rd(3'd4, 8'h00, "data_hi_empty");
        rd(3'd6, 8'h00, "reg6");

        strobe_n(1, 1'b0, 12'hABC);
        strobe_n(1, 1'b1, 12'h123);
        check("pending_after_push", {31'h0, out_pending}, 1);
        rd(3'd1, 8'h02, "level_lo_2");
        rd(3'd3, 8'hBC, "data_lo_w0");
        rd(3'd4, 8'h0A, "data_hi_w0");
        rd(3'd3, 8'h23, "data_lo_w1");
        rd(3'd4, 8'h11, "data_hi_w1");
        rd(3'd0, 8'h20, "status_drained");
        check("pending_drained", {31'h0, out_pending}, 0);

        strobe_n(258, 1'b0, 12'h000);
        rd(3'd0, 8'hC0, "status_overflow");
        rd(3'd2, 8'h01, "level_hi_full");
        rd(3'd1, 8'h00, "level_lo_full");
        rd(3'd5, 8'h02, "dropped_2");
        @(posedge clk); #1;
        host_clr = 1'b1;
        @(posedge clk); #1;
        host_clr = 1'b0;
        rd(3'd0, 8'h20, "status_cleared");
        rd(3'd5, 8'h00, "dropped_cleared");

        // Fill exactly: word i = {1, 12'h100+i}, so head DATA_HI = 8'h11.
        strobe_n(256, 1'b1, 12'h100);
        rd(3'd0, 8'h40, "status_full");
        do_read(3'd4, 8'h11, "pop_with_push", 0, 1'b1, 1'b1, 12'h5A5);
        rd(3'd2, 8'h01, "level_hi_still_full");
        rd(3'd1, 8'h00, "level_lo_still_full");
        rd(3'd5, 8'h00, "dropped_unchanged");
        rd(3'd0, 8'h40, "status_no_overflow");

        do_read(3'd4, 8'h11, "held_req_pop", 10, 1'b0, 1'b0, 12'h000);
        rd(3'd1, 8'hFF, "level_after_one_pop");
        rd(3'd3, 8'h02, "data_lo_next_head");

        // Reset while in FETCH: the pending request must never be acknowledged.
        @(posedge clk); #1;
        host_rd_addr = 3'd0;
        host_rd_req  = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        host_rd_req = 1'b0;
        check("midreset_ack", {31'h0, host_rd_ack}, 0);
        check("midreset_data", {24'h0, host_rd_data}, 0);
        check("midreset_pending", {31'h0, out_pending}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("midreset_ack_after", {31'h0, host_rd_ack}, 0);
        rd(3'd0, 8'h20, "status_after_midreset");
        rd(3'd1, 8'h00, "level_after_midreset");

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
